// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bus between the 5-stage datapath and pipe_hazard_ctrl.
// The master side is the datapath (D-stage instruction, compare result,
// memory ready); the slave side is the hazard/control unit.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W = 5
);
  logic [31:0]     instrd;
  logic            equald;
  logic            mem_ready;
  logic [1:0]      pcsrcd;
  logic            stallf;
  logic            stalld;
  logic            flushd;
  logic            flushe;
  logic            forwardad;
  logic            forwardbd;
  logic [1:0]      forwardae;
  logic [1:0]      forwardbe;
  logic [2:0]      alucontrole;
  logic            alusrce;
  logic            regdste;
  logic            memwritem;
  logic            memtoregw;
  logic            regwritew;
  logic [RA_W-1:0] writeregw;

  modport master (
    output instrd, equald, mem_ready,
    input  pcsrcd, stallf, stalld, flushd, flushe, forwardad, forwardbd,
           forwardae, forwardbe, alucontrole, alusrce, regdste, memwritem,
           memtoregw, regwritew, writeregw
  );

  modport slave (
    input  instrd, equald, mem_ready,
    output pcsrcd, stallf, stalld, flushd, flushe, forwardad, forwardbd,
           forwardae, forwardbe, alucontrole, alusrce, regdste, memwritem,
           memtoregw, regwritew, writeregw
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller for a 5-stage MIPS core: D-stage decode, E/M/W control
// registers, branch/jump resolution in D, stall/flush/forwarding generation
// and a whole-pipe freeze while a data-memory access waits for mem_ready.
// Optional feature: define BNE_EN to decode opcode 000101 as bne.
module pipe_hazard_ctrl #(
  parameter int FWD_EN = 1,
  parameter int RA_W   = 5
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  // ---------------- D-stage fields ----------------
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [RA_W-1:0] rsd;
  logic [RA_W-1:0] rtd;
  logic [RA_W-1:0] rdd;

  assign op    = bus.instrd[31:26];
  assign funct = bus.instrd[5:0];
  assign rsd   = bus.instrd[21 +: RA_W];
  assign rtd   = bus.instrd[16 +: RA_W];
  assign rdd   = bus.instrd[11 +: RA_W];

  // shamt (and any field bits above RA_W) carry no control meaning
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instrd;

  logic       regwrited;
  logic       memtoregd;
  logic       memwrited;
  logic       alusrcd;
  logic       regdstd;
  logic       branchd;
  logic       bned;
  logic       jumpd;
  logic [2:0] alucontrold;

  // Main decoder: opcode/funct to control bits, unknown opcodes become NOPs
  always_comb begin
    regwrited   = 1'b0;
    memtoregd   = 1'b0;
    memwrited   = 1'b0;
    alusrcd     = 1'b0;
    regdstd     = 1'b0;
    branchd     = 1'b0;
    bned        = 1'b0;
    jumpd       = 1'b0;
    alucontrold = 3'b000;
    case (op)
      6'b000000: begin
        regwrited = 1'b1;
        regdstd   = 1'b1;
        case (funct)
          6'b100000: alucontrold = 3'b010;
          6'b100010: alucontrold = 3'b110;
          6'b100100: alucontrold = 3'b000;
          6'b100101: alucontrold = 3'b001;
          6'b101010: alucontrold = 3'b111;
          default:   alucontrold = 3'b010;
        endcase
      end
      6'b100011: begin
        regwrited   = 1'b1;
        memtoregd   = 1'b1;
        alusrcd     = 1'b1;
        alucontrold = 3'b010;
      end
      6'b101011: begin
        memwrited   = 1'b1;
        alusrcd     = 1'b1;
        alucontrold = 3'b010;
      end
      6'b001000: begin
        regwrited   = 1'b1;
        alusrcd     = 1'b1;
        alucontrold = 3'b010;
      end
      6'b000100: begin
        branchd     = 1'b1;
        alucontrold = 3'b110;
      end
      6'b000010: begin
        jumpd = 1'b1;
      end
`ifdef BNE_EN
      6'b000101: begin
        branchd     = 1'b1;
        bned        = 1'b1;
        alucontrold = 3'b110;
      end
`else
`endif
      default: ;
    endcase
  end

  logic taken;
  assign taken = branchd & (bned ? ~bus.equald : bus.equald);

  // ---------------- stage registers ----------------
  logic            regwrite_e_reg;
  logic            memtoreg_e_reg;
  logic            memwrite_e_reg;
  logic            alusrc_e_reg;
  logic            regdst_e_reg;
  logic [2:0]      alucontrol_e_reg;
  logic [RA_W-1:0] rs_e_reg;
  logic [RA_W-1:0] rt_e_reg;
  logic [RA_W-1:0] rd_e_reg;

  logic            regwrite_m_reg;
  logic            memtoreg_m_reg;
  logic            memwrite_m_reg;
  logic [RA_W-1:0] writereg_m_reg;

  logic            regwrite_w_reg;
  logic            memtoreg_w_reg;
  logic [RA_W-1:0] writereg_w_reg;

  logic [RA_W-1:0] writereg_e;
  assign writereg_e = regdst_e_reg ? rd_e_reg : rt_e_reg;

  // ---------------- hazard detection ----------------
  function automatic logic hits(input logic [RA_W-1:0] dst,
                                input logic [RA_W-1:0] a,
                                input logic [RA_W-1:0] b);
    return (dst != '0) && ((dst == a) || (dst == b));
  endfunction

  logic hit_e;
  logic hit_m;
  logic load_use;
  logic branch_stall;
  logic raw_stall;
  logic d_stall;
  logic freeze;
  logic bubble;

  assign hit_e        = hits(writereg_e, rsd, rtd);
  assign hit_m        = hits(writereg_m_reg, rsd, rtd);
  assign load_use     = memtoreg_e_reg & regwrite_e_reg & hit_e;
  assign branch_stall = branchd & ((regwrite_e_reg & hit_e) | (memtoreg_m_reg & hit_m));
  // Without forwarding every in-flight producer in E or M must drain first
  assign raw_stall    = (FWD_EN == 0) & ((regwrite_e_reg & hit_e) | (regwrite_m_reg & hit_m));
  assign d_stall      = ~reset & (load_use | branch_stall | raw_stall);
  // A memory access in M that is not ready stalls the whole pipe and wins over d_stall
  assign freeze       = ~reset & ~bus.mem_ready & (memwrite_m_reg | memtoreg_m_reg);
  assign bubble       = d_stall & ~freeze;

  // E register: captures D controls; loads a bubble on a D stall, holds on freeze
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      regwrite_e_reg   <= 1'b0;
      memtoreg_e_reg   <= 1'b0;
      memwrite_e_reg   <= 1'b0;
      alusrc_e_reg     <= 1'b0;
      regdst_e_reg     <= 1'b0;
      alucontrol_e_reg <= 3'b000;
      rs_e_reg         <= '0;
      rt_e_reg         <= '0;
      rd_e_reg         <= '0;
    end else if (!freeze) begin
      regwrite_e_reg   <= regwrited;
      memtoreg_e_reg   <= memtoregd;
      memwrite_e_reg   <= memwrited;
      alusrc_e_reg     <= alusrcd;
      regdst_e_reg     <= regdstd;
      alucontrol_e_reg <= alucontrold;
      rs_e_reg         <= rsd;
      rt_e_reg         <= rtd;
      rd_e_reg         <= rdd;
    end
  end

  // M register: shifts from E unless the pipe is frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m_reg <= 1'b0;
      memtoreg_m_reg <= 1'b0;
      memwrite_m_reg <= 1'b0;
      writereg_m_reg <= '0;
    end else if (!freeze) begin
      regwrite_m_reg <= regwrite_e_reg;
      memtoreg_m_reg <= memtoreg_e_reg;
      memwrite_m_reg <= memwrite_e_reg;
      writereg_m_reg <= writereg_e;
    end
  end

  // W register: shifts from M unless the pipe is frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_w_reg <= 1'b0;
      memtoreg_w_reg <= 1'b0;
      writereg_w_reg <= '0;
    end else if (!freeze) begin
      regwrite_w_reg <= regwrite_m_reg;
      memtoreg_w_reg <= memtoreg_m_reg;
      writereg_w_reg <= writereg_m_reg;
    end
  end

  // ---------------- forwarding (operand A = rs, operand B = rt) ----------------
  logic [RA_W-1:0] src_d [2];
  logic [RA_W-1:0] src_e [2];
  logic            fwd_d [2];
  logic [1:0]      fwd_e [2];

  assign src_d[0] = rsd;
  assign src_d[1] = rtd;
  assign src_e[0] = rs_e_reg;
  assign src_e[1] = rt_e_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic m_match;
      logic w_match;
      assign m_match = regwrite_m_reg & (writereg_m_reg != '0) & (writereg_m_reg == src_e[gi]);
      assign w_match = regwrite_w_reg & (writereg_w_reg != '0) & (writereg_w_reg == src_e[gi]);
      assign fwd_d[gi] = (FWD_EN != 0) & ~reset & regwrite_m_reg &
                         (writereg_m_reg != '0) & (writereg_m_reg == src_d[gi]);
      // M is the younger producer, so it takes priority over W
      assign fwd_e[gi] = ((FWD_EN == 0) || reset) ? 2'b00 :
                         m_match ? 2'b10 :
                         w_match ? 2'b01 : 2'b00;
    end
  endgenerate

  logic stall_out;
  logic flushd_out;
  logic flushe_out;

  // Stall/flush arbitration: freeze beats a D stall, a D stall beats a redirect flush
  always_comb begin
    stall_out  = 1'b0;
    flushd_out = 1'b0;
    flushe_out = 1'b0;
    if (reset) begin
      stall_out = 1'b0;
    end else if (freeze) begin
      stall_out = 1'b1;
    end else if (d_stall) begin
      stall_out  = 1'b1;
      flushe_out = 1'b1;
    end else begin
      flushd_out = jumpd | taken;
    end
  end

  // ---------------- outputs ----------------
  assign bus.pcsrcd      = reset ? 2'b00 : {jumpd, taken};
  assign bus.stallf      = stall_out;
  assign bus.stalld      = stall_out;
  assign bus.flushd      = flushd_out;
  assign bus.flushe      = flushe_out;
  assign bus.forwardad   = fwd_d[0];
  assign bus.forwardbd   = fwd_d[1];
  assign bus.forwardae   = fwd_e[0];
  assign bus.forwardbe   = fwd_e[1];
  assign bus.alucontrole = alucontrol_e_reg;
  assign bus.alusrce     = alusrc_e_reg;
  assign bus.regdste     = regdst_e_reg;
  assign bus.memwritem   = memwrite_m_reg;
  assign bus.memtoregw   = memtoreg_w_reg;
  // The register file must not be written while the W instruction is held
  assign bus.regwritew   = regwrite_w_reg & ~freeze;
  assign bus.writeregw   = writereg_w_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed instruction sequence with a queue
// of expected per-stage control records (pushed as instructions enter E,
// popped as they leave W). A second instance with FWD_EN=0 checks
// interlock-only mode. Honours BNE_EN when defined.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RA_W(5)) bus ();
  pipe_hazard_ctrl_if #(.RA_W(5)) bus_il ();

  assign bus_il.instrd    = bus.instrd;
  assign bus_il.equald    = bus.equald;
  assign bus_il.mem_ready = bus.mem_ready;

  pipe_hazard_ctrl #(.FWD_EN(1), .RA_W(5)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  pipe_hazard_ctrl #(.FWD_EN(0), .RA_W(5)) u_il  (.clk(clk), .reset(reset), .bus(bus_il));

  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       mw;
    logic [2:0] alu;
    logic       alus;
    logic       rdst;
    logic [4:0] wr;
  } rec_t;

  // Instruction encodings
  localparam logic [31:0] ADD3  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
  localparam logic [31:0] SUB4  = {6'b000000, 5'd3, 5'd1, 5'd4, 5'd0, 6'b100010};
  localparam logic [31:0] AND5  = {6'b000000, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100100};
  localparam logic [31:0] LW2   = {6'b100011, 5'd0, 5'd2, 16'h0000};
  localparam logic [31:0] ADD5  = {6'b000000, 5'd2, 5'd2, 5'd5, 5'd0, 6'b100000};
  localparam logic [31:0] BEQ11 = {6'b000100, 5'd1, 5'd1, 16'h0000};
  localparam logic [31:0] JMP   = {6'b000010, 26'h0};
  localparam logic [31:0] ADD1  = {6'b000000, 5'd2, 5'd3, 5'd1, 5'd0, 6'b100000};
  localparam logic [31:0] BEQ10 = {6'b000100, 5'd1, 5'd0, 16'h0000};
  localparam logic [31:0] ADD6  = {6'b000000, 5'd1, 5'd1, 5'd6, 5'd0, 6'b100000};
  localparam logic [31:0] SW4   = {6'b101011, 5'd0, 5'd4, 16'h0000};
  localparam logic [31:0] NOP   = 32'hFC00_0000;
  localparam logic [31:0] BNE12 = {6'b000101, 5'd1, 5'd2, 16'h0000};
  localparam logic [31:0] BEQ00 = {6'b000100, 5'd0, 5'd0, 16'h0000};
  localparam logic [31:0] OR7   = {6'b000000, 5'd1, 5'd2, 5'd7, 5'd0, 6'b100101};
  localparam logic [31:0] SLT8  = {6'b000000, 5'd1, 5'd2, 5'd8, 5'd0, 6'b101010};
  localparam logic [31:0] SLL9  = {6'b000000, 5'd0, 5'd0, 5'd9, 5'd0, 6'b000000};
  localparam logic [31:0] ADDI  = {6'b001000, 5'd1, 5'd10, 16'h0005};

  // Expected stage records {rw, mtr, mw, alu, alusrc, regdst, writereg}
  localparam rec_t ZREC    = '0;
  localparam rec_t R_ADD3  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd3};
  localparam rec_t R_SUB4  = {1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 5'd4};
  localparam rec_t R_AND5  = {1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd5};
  localparam rec_t R_LW2   = {1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 5'd2};
  localparam rec_t R_ADD5  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd5};
  localparam rec_t R_BEQ11 = {1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 5'd1};
  localparam rec_t R_ADD1  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd1};
  localparam rec_t R_BEQ10 = {1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 5'd0};
  localparam rec_t R_ADD6  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd6};
  localparam rec_t R_SW4   = {1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 5'd4};
  localparam rec_t R_BEQ00 = {1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 5'd0};
  localparam rec_t R_OR7   = {1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 5'd7};
  localparam rec_t R_SLT8  = {1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 5'd8};
  localparam rec_t R_SLL9  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd9};
  localparam rec_t R_ADDI  = {1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 5'd10};
`ifdef BNE_EN
  localparam rec_t R_BNE12 = {1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 5'd2};
  localparam logic [1:0] BNE_PC = 2'b01;
  localparam logic       BNE_FD = 1'b1;
`else
  localparam rec_t R_BNE12 = {1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd2};
  localparam logic [1:0] BNE_PC = 2'b00;
  localparam logic       BNE_FD = 1'b0;
`endif

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_q();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(ZREC);
  endtask

  // Hold reset across one clock edge and check that every output is cleared
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    bus.instrd = JMP;
    bus.equald = 1'b1;
    bus.mem_ready = rdy;
    @(posedge clk);
    #1;
    chk("rst.pcsrcd",      8'(bus.pcsrcd),      8'h0);
    chk("rst.stallf",      8'(bus.stallf),      8'h0);
    chk("rst.stalld",      8'(bus.stalld),      8'h0);
    chk("rst.flushd",      8'(bus.flushd),      8'h0);
    chk("rst.flushe",      8'(bus.flushe),      8'h0);
    chk("rst.forwardae",   8'(bus.forwardae),   8'h0);
    chk("rst.alucontrole", 8'(bus.alucontrole), 8'h0);
    chk("rst.memwritem",   8'(bus.memwritem),   8'h0);
    chk("rst.regwritew",   8'(bus.regwritew),   8'h0);
    chk("rst.writeregw",   8'(bus.writeregw),   8'h0);
    @(negedge clk);
    reset = 1'b0;
    init_q();
  endtask

  // One main-pipe cycle: drive D inputs, check D outputs and the E/M/W
  // records at the head of the scoreboard, then enqueue what enters E.
  task automatic step(input string tag, input logic [31:0] ins, input logic eq,
                      input logic rdy, input logic [1:0] pc, input logic st,
                      input logic fd, input logic fz, input logic [1:0] fae,
                      input logic [1:0] fbe, input logic fad, input logic fbd,
                      input rec_t nr);
    rec_t re, rm, rw;
    bus.instrd = ins;
    bus.equald = eq;
    bus.mem_ready = rdy;
    #1;
    re = q[q.size()-1];
    rm = q[q.size()-2];
    rw = q[q.size()-3];
    chk({tag, ".pcsrcd"},      8'(bus.pcsrcd),      8'(pc));
    chk({tag, ".stallf"},      8'(bus.stallf),      8'(st | fz));
    chk({tag, ".stalld"},      8'(bus.stalld),      8'(st | fz));
    chk({tag, ".flushd"},      8'(bus.flushd),      8'(fd));
    chk({tag, ".flushe"},      8'(bus.flushe),      8'(st & ~fz));
    chk({tag, ".forwardae"},   8'(bus.forwardae),   8'(fae));
    chk({tag, ".forwardbe"},   8'(bus.forwardbe),   8'(fbe));
    chk({tag, ".forwardad"},   8'(bus.forwardad),   8'(fad));
    chk({tag, ".forwardbd"},   8'(bus.forwardbd),   8'(fbd));
    chk({tag, ".alucontrole"}, 8'(bus.alucontrole), 8'(re.alu));
    chk({tag, ".alusrce"},     8'(bus.alusrce),     8'(re.alus));
    chk({tag, ".regdste"},     8'(bus.regdste),     8'(re.rdst));
    chk({tag, ".memwritem"},   8'(bus.memwritem),   8'(rm.mw));
    chk({tag, ".memtoregw"},   8'(bus.memtoregw),   8'(rw.mtr));
    chk({tag, ".regwritew"},   8'(bus.regwritew),   8'(fz ? 1'b0 : rw.rw));
    chk({tag, ".writeregw"},   8'(bus.writeregw),   8'(rw.wr));
    if (!fz) begin
      q.push_back(st ? ZREC : nr);
      if (q.size() > 3) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  // One cycle of the interlock-only instance
  task automatic step_il(input string tag, input logic [31:0] ins,
                         input logic st, input logic fad);
    bus.instrd = ins;
    bus.equald = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk({tag, ".il_stalld"},    8'(bus_il.stalld),    8'(st));
    chk({tag, ".il_flushe"},    8'(bus_il.flushe),    8'(st));
    chk({tag, ".il_forwardad"}, 8'(bus_il.forwardad), 8'(fad));
    chk({tag, ".il_forwardae"}, 8'(bus_il.forwardae), 8'h0);
    @(negedge clk);
  endtask

  initial begin
    bus.instrd = NOP;
    bus.equald = 1'b0;
    bus.mem_ready = 1'b1;

    // Interlock-only: add $3 then sub $4,$3,$1 stalls once per producer stage
    do_reset(1'b1);
    step_il("il0_add3", ADD3, 1'b0, 1'b0);
    step_il("il1_sub",  SUB4, 1'b1, 1'b0);
    step_il("il2_sub",  SUB4, 1'b1, 1'b0);
    step_il("il3_sub",  SUB4, 1'b0, 1'b0);
    step_il("il4_nop",  NOP,  1'b0, 1'b0);

    // Full forwarding pipe
    do_reset(1'b1);
    //           tag        instr  eq    rdy   pc     st    fd    fz    fae    fbe    fad   fbd   record
    step("m0_add3",  ADD3,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_ADD3);
    step("m1_sub",   SUB4,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_SUB4);
    step("m2_and",   AND5,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, R_AND5);
    step("m3_lw",    LW2,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_LW2);
    step("m4_lwuse", ADD5,  1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_ADD5);
    step("m5_add5",  ADD5,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, R_ADD5);
    step("m6_beq",   BEQ11, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, R_BEQ11);
    step("m7_j",     JMP,   1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m8_add1",  ADD1,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_ADD1);
    step("m9_bstl",  BEQ10, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_BEQ10);
    step("m10_beq",  BEQ10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, R_BEQ10);
    step("m11_add6", ADD6,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, R_ADD6);
    step("m12_sw",   SW4,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_SW4);
    step("m13_nop",  NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m14_frz",  NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m15_frz",  NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m16_frz",  NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m17_go",   NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m18_bne",  BNE12, 1'b0, 1'b1, BNE_PC, 1'b0, BNE_FD, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_BNE12);
    step("m19_beqn", BEQ00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_BEQ00);
    step("m20_or",   OR7,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_OR7);
    step("m21_slt",  SLT8,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_SLT8);
    step("m22_sll",  SLL9,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_SLL9);
    step("m23_addi", ADDI,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_ADDI);
    step("m24_nop",  NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m25_nop",  NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m26_nop",  NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m27_sw",   SW4,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, R_SW4);
    step("m28_nop",  NOP,   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m29_frz",  NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);
    step("m30_frz",  NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);

    // Reset in the middle of a freeze leaves nothing behind
    do_reset(1'b0);
    step("m31_post", NOP,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ZREC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
